spi_frame_scheduler: RTL and testbench

Sits between the SPI slave receiver and the register-write fabric. Gates the receiver's write enable, validates each 64-bit frame (header, checksum, sequence), and dispatches accepted frames as address/data commands over a valid/ready handshake. Provides a ready-timeout, per-cause error pulses and saturating status counters for the control-status block.

---
 rtl/spi_frame_scheduler.sv | 199 +++++++++++++++++++
 tb/tb_spi_frame_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// spi_frame_scheduler : validates 64-bit SPI frames, dispatches addr/data cmds
// Revision 1.0
// ============================================================================
module spi_frame_scheduler #(
  parameter logic [7:0]  HEADER  = 8'hA5,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_enable,
  output logic             spi_wr_en,
  input  logic             rxd_flag,
  input  logic [63:0]      rxd_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [7:0]       cmd_addr,
  output logic [31:0]      cmd_data,
  output logic             err_hdr,
  output logic             err_sum,
  output logic             err_seq,
  output logic             err_tmo,
  output logic             err_ovf,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned     WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHECK    = 2'd1,
    ST_DISPATCH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       frame_q, frame_d;
  logic [7:0]        last_seq_q, last_seq_d;
  logic              seq_valid_q, seq_valid_d;
  logic              rx_en_prev_q, rx_en_prev_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              spi_wr_en_q, spi_wr_en_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [7:0]        cmd_addr_q, cmd_addr_d;
  logic [31:0]       cmd_data_q, cmd_data_d;
  logic              err_hdr_q, err_hdr_d;
  logic              err_sum_q, err_sum_d;
  logic              err_seq_q, err_seq_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_ovf_q, err_ovf_d;
  logic [CNT_W-1:0]  ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [7:0]        w_sum;
  logic [1:0]        w_err_inc;
  logic              w_ok_inc;
  logic [CNT_W:0]    w_err_sum_ext;
  logic [CNT_W:0]    w_ok_sum_ext;

  assign w_sum = frame_q[63:56] ^ frame_q[55:48] ^ frame_q[47:40] ^ frame_q[39:32]
               ^ frame_q[31:24] ^ frame_q[23:16] ^ frame_q[15:8];

  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    last_seq_d   = last_seq_q;
    seq_valid_d  = seq_valid_q;
    rx_en_prev_d = rx_enable;
    wait_d       = wait_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_data_d   = cmd_data_q;
    err_hdr_d    = 1'b0;
    err_sum_d    = 1'b0;
    err_seq_d    = 1'b0;
    err_tmo_d    = 1'b0;
    err_ovf_d    = 1'b0;
    w_err_inc    = 2'd0;
    w_ok_inc     = 1'b0;
    spi_wr_en_d  = rx_enable && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (rxd_flag) begin
          frame_d = rxd_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (frame_q[63:56] != HEADER) begin
          err_hdr_d = 1'b1;
          w_err_inc = 2'd1;
          state_d   = ST_IDLE;
        end else if (w_sum != frame_q[7:0]) begin
          err_sum_d = 1'b1;
          w_err_inc = 2'd1;
          state_d   = ST_IDLE;
        end else begin
          err_seq_d   = seq_valid_q && (frame_q[15:8] != last_seq_q + 8'd1);
          last_seq_d  = frame_q[15:8];
          seq_valid_d = 1'b1;
          cmd_addr_d  = frame_q[55:48];
          cmd_data_d  = frame_q[47:16];
          cmd_valid_d = 1'b1;
          wait_d      = '0;
          state_d     = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        // Accept takes priority over a timeout landing in the same cycle.
        if (cmd_ready) begin
          w_ok_inc    = 1'b1;
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (wait_q == WAIT_LAST) begin
          err_tmo_d   = 1'b1;
          w_err_inc   = 2'd1;
          cmd_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rxd_flag && (state_q != ST_IDLE)) begin
      err_ovf_d = 1'b1;
      w_err_inc = w_err_inc + 2'd1;
    end

    // A fresh enable starts a new sequence; clearing wins over a same-cycle set.
    if (rx_enable && !rx_en_prev_q) begin
      seq_valid_d = 1'b0;
    end

    w_err_sum_ext = {1'b0, err_cnt_q} + (CNT_W+1)'(w_err_inc);
    w_ok_sum_ext  = {1'b0, ok_cnt_q} + (CNT_W+1)'(w_ok_inc);
    err_cnt_d     = w_err_sum_ext[CNT_W] ? '1 : w_err_sum_ext[CNT_W-1:0];
    ok_cnt_d      = w_ok_sum_ext[CNT_W]  ? '1 : w_ok_sum_ext[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      frame_q      <= '0;
      last_seq_q   <= '0;
      seq_valid_q  <= 1'b0;
      rx_en_prev_q <= 1'b0;
      wait_q       <= '0;
      spi_wr_en_q  <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_data_q   <= '0;
      err_hdr_q    <= 1'b0;
      err_sum_q    <= 1'b0;
      err_seq_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      ok_cnt_q     <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      last_seq_q   <= last_seq_d;
      seq_valid_q  <= seq_valid_d;
      rx_en_prev_q <= rx_en_prev_d;
      wait_q       <= wait_d;
      spi_wr_en_q  <= spi_wr_en_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_data_q   <= cmd_data_d;
      err_hdr_q    <= err_hdr_d;
      err_sum_q    <= err_sum_d;
      err_seq_q    <= err_seq_d;
      err_tmo_q    <= err_tmo_d;
      err_ovf_q    <= err_ovf_d;
      ok_cnt_q     <= ok_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign spi_wr_en = spi_wr_en_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign err_hdr   = err_hdr_q;
  assign err_sum   = err_sum_q;
  assign err_seq   = err_seq_q;
  assign err_tmo   = err_tmo_q;
  assign err_ovf   = err_ovf_q;
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_spi_frame_scheduler : randomized self-checking bench with frame-level model
// Revision 1.0
// ============================================================================
module tb_spi_frame_scheduler;

  localparam int TMO = 8;
  localparam int CW  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, rx_enable, spi_wr_en, rxd_flag, cmd_valid, cmd_ready;
  logic [63:0]   rxd_data;
  logic [7:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic          err_hdr, err_sum, err_seq, err_tmo, err_ovf;
  logic [CW-1:0] ok_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  // Frame-level reference state
  int         m_ok, m_err;
  int         m_last;
  bit         m_sv;

  spi_frame_scheduler #(.HEADER(8'hA5), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .spi_wr_en(spi_wr_en),
    .rxd_flag(rxd_flag), .rxd_data(rxd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .err_hdr(err_hdr), .err_sum(err_sum), .err_seq(err_seq), .err_tmo(err_tmo),
    .err_ovf(err_ovf), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] mk(input logic [7:0] h, input logic [7:0] a,
                                     input logic [31:0] d, input logic [7:0] s);
    logic [7:0] cs;
    cs = h ^ a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ s;
    return {h, a, d, s, cs};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; rxd_flag = 1'b0; cmd_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_ok = 0; m_err = 0; m_sv = 1'b0; m_last = 0;
  endtask

  // Sends one frame while IDLE, services the handshake after `delay` cycles
  // of cmd_valid (never if delay >= TMO), and checks everything observable.
  task automatic run_frame(input logic [63:0] f, input int delay);
    bit hdr_ok, sum_ok, exp_seq, acc, unstable;
    logic [7:0] cs;
    int n, want_hi;
    hdr_ok  = (f[63:56] == 8'hA5);
    cs      = f[63:56] ^ f[55:48] ^ f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
    sum_ok  = (cs == f[7:0]);
    exp_seq = 1'b0;
    acc     = 1'b0;
    if (hdr_ok && sum_ok) begin
      exp_seq = m_sv && (int'(f[15:8]) != (m_last + 1) % 256);
      m_last  = int'(f[15:8]);
      m_sv    = 1'b1;
      acc     = (delay < TMO);
      if (acc) m_ok++; else m_err++;
    end else begin
      m_err++;
    end

    @(negedge clk);
    checks++; if (spi_wr_en !== rx_enable) begin errors++; $display("FAIL idle_wr_en: got %b want %b", spi_wr_en, rx_enable); end
    rxd_flag = 1'b1; rxd_data = f; cmd_ready = 1'b0;
    @(negedge clk);
    rxd_flag = 1'b0;
    @(negedge clk);
    checks++; if (err_hdr !== !hdr_ok) begin errors++; $display("FAIL err_hdr: got %b want %b", err_hdr, !hdr_ok); end
    checks++; if (err_sum !== (hdr_ok && !sum_ok)) begin errors++; $display("FAIL err_sum: got %b want %b", err_sum, hdr_ok && !sum_ok); end
    checks++; if (err_seq !== exp_seq) begin errors++; $display("FAIL err_seq: got %b want %b", err_seq, exp_seq); end
    checks++; if (cmd_valid !== (hdr_ok && sum_ok)) begin errors++; $display("FAIL cmd_valid_rise: got %b want %b", cmd_valid, hdr_ok && sum_ok); end
    checks++; if (spi_wr_en !== 1'b0) begin errors++; $display("FAIL busy_wr_en: got %b want 0", spi_wr_en); end

    if (hdr_ok && sum_ok) begin
      n = 0;
      unstable = 1'b0;
      while (cmd_valid === 1'b1 && n < TMO + 4) begin
        if (cmd_addr !== f[55:48] || cmd_data !== f[47:16]) unstable = 1'b1;
        cmd_ready = (n == delay);
        @(negedge clk);
        n++;
      end
      cmd_ready = 1'b0;
      want_hi = acc ? delay + 1 : TMO;
      checks++; if (unstable) begin errors++; $display("FAIL cmd_payload: got %h_%h want %h_%h", cmd_addr, cmd_data, f[55:48], f[47:16]); end
      checks++; if (n != want_hi) begin errors++; $display("FAIL valid_cycles: got %0d want %0d", n, want_hi); end
      checks++; if (err_tmo !== !acc) begin errors++; $display("FAIL err_tmo: got %b want %b", err_tmo, !acc); end
    end
    checks++; if (int'(ok_cnt) != sat(m_ok)) begin errors++; $display("FAIL ok_cnt: got %0d want %0d", ok_cnt, sat(m_ok)); end
    checks++; if (int'(err_cnt) != sat(m_err)) begin errors++; $display("FAIL err_cnt: got %0d want %0d", err_cnt, sat(m_err)); end
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_enable = 1'b1; rxd_flag = 1'b0; rxd_data = '0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({spi_wr_en, cmd_valid, cmd_addr, cmd_data, err_hdr, err_sum, err_seq, err_tmo, err_ovf, ok_cnt, err_cnt} !== '0) begin
      errors++; $display("FAIL reset_outputs: got wr=%b v=%b a=%h d=%h ok=%0d err=%0d want all 0", spi_wr_en, cmd_valid, cmd_addr, cmd_data, ok_cnt, err_cnt);
    end
    rst = 1'b0;
    m_ok = 0; m_err = 0; m_sv = 1'b0; m_last = 0;
    @(negedge clk);
  endtask

  task automatic test_valid_frame();
    run_frame(mk(8'hA5, 8'h10, 32'hDEADBEEF, 8'h01), 0);
  endtask

  task automatic test_bad_frames();
    logic [63:0] f;
    run_frame(mk(8'h5A, 8'h22, 32'h12345678, 8'h02), 0);
    f = mk(8'hA5, 8'h22, 32'h12345678, 8'h02);
    f[3] = ~f[3];
    run_frame(f, 0);
  endtask

  task automatic test_seq();
    do_reset();
    run_frame(mk(8'hA5, 8'h01, 32'h1, 8'h01), 0);
    run_frame(mk(8'hA5, 8'h02, 32'h2, 8'h03), 1);
    run_frame(mk(8'hA5, 8'h03, 32'h3, 8'hFF), 0);
    run_frame(mk(8'hA5, 8'h04, 32'h4, 8'h00), 2);
  endtask

  task automatic test_timeout();
    run_frame(mk(8'hA5, 8'h30, 32'hCAFEF00D, 8'h01), 1000);
    run_frame(mk(8'hA5, 8'h31, 32'h0BADC0DE, 8'h02), TMO - 1);
  endtask

  task automatic test_overflow();
    logic [63:0] f;
    f = mk(8'hA5, 8'h44, 32'hA1B2C3D4, 8'h03);
    @(negedge clk);
    rxd_flag = 1'b1; rxd_data = f;
    @(negedge clk);
    rxd_flag = 1'b0;
    @(negedge clk);
    rxd_flag = 1'b1; rxd_data = mk(8'hA5, 8'h99, 32'hFFFFFFFF, 8'h04);
    @(negedge clk);
    rxd_flag = 1'b0;
    m_err++;
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_ovf: got %b want 1", err_ovf); end
    checks++; if (int'(err_cnt) != sat(m_err)) begin errors++; $display("FAIL ovf_err_cnt: got %0d want %0d", err_cnt, sat(m_err)); end
    @(negedge clk);
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_width: got %b want 0", err_ovf); end
    checks++; if (spi_wr_en !== 1'b0) begin errors++; $display("FAIL ovf_wr_en: got %b want 0", spi_wr_en); end
    checks++; if (cmd_valid !== 1'b1 || cmd_addr !== 8'h44 || cmd_data !== 32'hA1B2C3D4) begin
      errors++; $display("FAIL ovf_cmd_intact: got v=%b %h_%h want 1 44_a1b2c3d4", cmd_valid, cmd_addr, cmd_data);
    end
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    m_ok++; m_sv = 1'b1; m_last = 3;
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL ovf_handshake: got %b want 0", cmd_valid); end
    checks++; if (int'(ok_cnt) != sat(m_ok)) begin errors++; $display("FAIL ovf_ok_cnt: got %0d want %0d", ok_cnt, sat(m_ok)); end
  endtask

  task automatic test_rx_enable();
    @(negedge clk);
    rx_enable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (spi_wr_en !== 1'b0) begin errors++; $display("FAIL disabled_wr_en: got %b want 0", spi_wr_en); end
    rx_enable = 1'b1;
    m_sv = 1'b0;
    run_frame(mk(8'hA5, 8'h55, 32'h55AA55AA, 8'(m_last + 7)), 0);
  endtask

  task automatic test_random();
    logic [7:0] h, s;
    logic [63:0] f;
    int kind, bitpos;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      h = 8'hA5;
      if (kind == 0) begin
        h = 8'($urandom);
        if (h == 8'hA5) h = 8'h5A;
      end
      s = ($urandom_range(0, 1) == 1) ? 8'(m_last + 1) : 8'($urandom);
      f = mk(h, 8'($urandom), 32'($urandom), s);
      if (kind == 1) begin
        bitpos = $urandom_range(0, 7);
        f[bitpos] = ~f[bitpos];
      end
      run_frame(f, $urandom_range(0, TMO + 1));
    end
  endtask

  // Overflow pulses on every CHECK/DISPATCH cycle of a timed-out frame:
  // 9 overflows + 1 timeout per frame, the last two in the same cycle.
  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 26; k++) begin
      @(negedge clk);
      rxd_flag = 1'b1; rxd_data = mk(8'hA5, 8'h60, 32'(k), 8'(k)); cmd_ready = 1'b0;
      @(negedge clk);
      repeat (9) @(negedge clk);
      rxd_flag = 1'b0;
      m_err = m_err + 10;
      checks++; if (err_tmo !== 1'b1 || err_ovf !== 1'b1) begin errors++; $display("FAIL sat_coincide: got tmo=%b ovf=%b want 1 1", err_tmo, err_ovf); end
      checks++; if (int'(err_cnt) != sat(m_err)) begin errors++; $display("FAIL sat_err_cnt: got %0d want %0d", err_cnt, sat(m_err)); end
    end
    m_sv = 1'b1; m_last = 25;
    for (int k = 0; k < 3; k++) run_frame(mk(8'h00, 8'h01, 32'h0, 8'h00), 0);
  endtask

  task automatic test_rst_mid_dispatch();
    @(negedge clk);
    rxd_flag = 1'b1; rxd_data = mk(8'hA5, 8'h77, 32'h77777777, 8'h1A); cmd_ready = 1'b0;
    @(negedge clk);
    rxd_flag = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", cmd_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({spi_wr_en, cmd_valid, cmd_addr, cmd_data, err_hdr, err_sum, err_seq, err_tmo, err_ovf, ok_cnt, err_cnt} !== '0) begin
      errors++; $display("FAIL rst_mid_dispatch: got wr=%b v=%b a=%h d=%h ok=%0d err=%0d want all 0", spi_wr_en, cmd_valid, cmd_addr, cmd_data, ok_cnt, err_cnt);
    end
    rst = 1'b0;
    m_ok = 0; m_err = 0; m_sv = 1'b0; m_last = 0;
    repeat (2) @(negedge clk);
    run_frame(mk(8'hA5, 8'h78, 32'h13579BDF, 8'h40), 3);
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_frames();
    test_seq();
    test_timeout();
    test_overflow();
    test_rx_enable();
    test_random();
    test_saturation();
    test_rst_mid_dispatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
